// File: rtl/step_ctrl_pkg.sv
// Shared types and constants for the single-step / run controller.
// Holds the FSM state and mode encodings and the reset tick divisor.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STEP   = 2'b01,
        ST_RUN    = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_STEP = 2'b01,
        MODE_AUTO = 2'b10,
        MODE_FREE = 2'b11
    } mode_t;

    localparam int DEFAULT_DIV = 100000000;

endpackage

// File: rtl/step_controller_if.sv
// Control/status bundle between a debug host and step_controller.
// master: host side (drives mode/step/halt/divisor, reads status).
// slave : controller side (reads requests, drives cpu_en/tick/state/count).
interface step_controller_if #(
    parameter int DIV_W = 27,
    parameter int CNT_W = 16
);

    logic [1:0]       mode;
    logic             step_btn;
    logic             halt_req;
    logic             resume;
    logic             div_load;
    logic [DIV_W-1:0] div_value;
    logic             cpu_en;
    logic             tick;
    logic [1:0]       state;
    logic [CNT_W-1:0] step_count;

    modport master (
        output mode,
        output step_btn,
        output halt_req,
        output resume,
        output div_load,
        output div_value,
        input  cpu_en,
        input  tick,
        input  state,
        input  step_count
    );

    modport slave (
        input  mode,
        input  step_btn,
        input  halt_req,
        input  resume,
        input  div_load,
        input  div_value,
        output cpu_en,
        output tick,
        output state,
        output step_count
    );

endinterface

// File: rtl/step_controller_tick_div.sv
// Programmable tick divider: one-cycle tick every div CLK cycles.
// Ports: CLK, RST (sync, high), load/div_value (reprogram), tick (out).
module tick_div #(
    parameter int DIV_W       = 27,
    parameter int DEFAULT_DIV = 100000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [DIV_W-1:0] div_value,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] RST_DIV =
        (DEFAULT_DIV < 2) ? ONE : DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] cnt;
    logic             wrap;

    // >= rather than == keeps the counter bounded whatever div_r holds
    assign wrap = (cnt >= (div_r - ONE));

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_r <= RST_DIV;
            cnt   <= '0;
            tick  <= 1'b0;
        end else if (load) begin
            // 0 and 1 both mean "tick every cycle"
            div_r <= (div_value <= ONE) ? ONE : div_value;
            cnt   <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= wrap;
            cnt  <= wrap ? '0 : cnt + ONE;
        end
    end

endmodule

// File: rtl/step_controller.sv
// Processor clock-enable controller: single-step, divided auto-run,
// free-run and halt. Ports: CLK, RST (sync, high), bus (slave side).
module step_controller #(
    parameter int DEFAULT_DIV = step_ctrl_pkg::DEFAULT_DIV,
    parameter int DIV_W       = 27,
    parameter int CNT_W       = 16
) (
    input  logic               CLK,
    input  logic               RST,
    step_controller_if.slave   bus
);

    import step_ctrl_pkg::*;

    state_t           state_q;
    state_t           state_d;
    mode_t            mode;
    logic             btn_q;
    logic             btn_q2;
    logic             step_ev;
    logic             tick_w;
    logic             cpu_en_q;
    logic             cpu_en_d;
    logic             resume_ok;
    logic [CNT_W-1:0] count_q;

    assign mode = mode_t'(bus.mode);

    tick_div #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_div (
        .CLK       (CLK),
        .RST       (RST),
        .load      (bus.div_load),
        .div_value (bus.div_value),
        .tick      (tick_w)
    );

    // Two-stage sample: btn_q is the registered button, btn_q2 its
    // previous value, so a held button produces one rising event.
    always_ff @(posedge CLK) begin
        if (RST) begin
            btn_q  <= 1'b0;
            btn_q2 <= 1'b0;
        end else begin
            btn_q  <= bus.step_btn;
            btn_q2 <= btn_q;
        end
    end

    assign step_ev = btn_q & ~btn_q2;

    assign resume_ok = (state_q == ST_HALTED)
                     & bus.resume & ~bus.halt_req;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.halt_req) begin
                    state_d = ST_HALTED;
                end else if (mode == MODE_STEP && step_ev) begin
                    state_d = ST_STEP;
                end else if (mode == MODE_AUTO
                          || mode == MODE_FREE) begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                state_d = bus.halt_req ? ST_HALTED : ST_IDLE;
            end
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_d = ST_HALTED;
                end else if (mode == MODE_HALT
                          || mode == MODE_STEP) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (resume_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Enable for the following cycle; a sampled halt_req always wins.
    always_comb begin
        cpu_en_d = 1'b0;
        if (!bus.halt_req) begin
            unique case (state_q)
                ST_STEP: cpu_en_d = 1'b1;
                ST_RUN: begin
                    cpu_en_d = (mode == MODE_FREE)
                             | ((mode == MODE_AUTO) & tick_w);
                end
                default: cpu_en_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cpu_en_q <= 1'b0;
        end else begin
            cpu_en_q <= cpu_en_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else if (resume_ok) begin
            count_q <= '0;
        end else if (cpu_en_q && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.tick       = tick_w;
    assign bus.state      = state_q;
    assign bus.step_count = count_q;

endmodule

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 100000000, meaning reset value of the tick divisor (CLK cycles per tick).
REQ-002 SHALL have parameter DIV_W, default 27, meaning divisor width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning step_count width.
REQ-004 SHALL have port CLK, input, 1, system clock; the block has one clock.
REQ-005 SHALL have port RST, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port mode, input, 2, 00 HALT, 01 STEP, 10 AUTO, 11 FREE.
REQ-007 SHALL have port step_btn, input, 1, debounced single-step request level.
REQ-008 SHALL have port halt_req, input, 1, processor halt request, level.
REQ-009 SHALL have port resume, input, 1, exits HALTED state, one-cycle pulse.
REQ-010 SHALL have port div_load, input, 1, latches div_value into the tick divisor.
REQ-011 SHALL have port div_value, input, DIV_W, new tick divisor.
REQ-012 SHALL have port cpu_en, output, 1, processor clock-enable, registered.
REQ-013 SHALL have port tick, output, 1, one-cycle tick pulse from the divider.
REQ-014 SHALL have port state, output, 2, current FSM state encoding.
REQ-015 SHALL have port step_count, output, CNT_W, number of cycles cpu_en was high.

Function
REQ-016 Divider SHALL count 0..div-1 and assert tick for exactly one cycle when count==div-1, then wrap to 0.
- div_value of 0 or 1 is treated as 1: tick every cycle.
REQ-017 On div_load, the divider SHALL latch div_value and clear count in the same edge.
- No tick is asserted in the load cycle.
- First tick occurs div cycles later, including during RUN.
REQ-018 step_btn SHALL be registered.
- A step event is a 0→1 change of the registered sample.
- Holding the button yields one event.
REQ-019 FSM SHALL have states IDLE=00, STEP=01, RUN=10, HALTED=11.
REQ-020 IDLE SHALL go to STEP on a step event with mode STEP, and to RUN when mode is AUTO or FREE; otherwise it SHALL remain in IDLE.
REQ-021 STEP SHALL last exactly one cycle and then SHALL return to IDLE, regardless of mode.
REQ-022 RUN SHALL return to IDLE on the edge after mode becomes HALT or STEP.
REQ-023 halt_req sampled high in IDLE, STEP or RUN SHALL enter HALTED on that edge.
- halt_req has priority over step events and mode.
REQ-024 HALTED SHALL be left only on resume (→IDLE) or RST; halt_req must be low for resume to take effect.
REQ-025 cpu_en SHALL be registered:
- high for exactly one cycle following the STEP state;
- in RUN/AUTO, high for one cycle following each tick;
- in RUN/FREE, continuously high;
- otherwise 0.
REQ-026 Step latency SHALL be fixed: step_btn registered high at edge k (previously low) gives cpu_en high between edges k+2 and k+3 only.
REQ-027 cpu_en SHALL be 0 in the cycle after halt_req is sampled high.
REQ-028 step_count SHALL increment on each cycle cpu_en is high, saturate at all-ones, and clear on resume.

Reset
REQ-029 On RST the block SHALL set state=IDLE, cpu_en=0, tick=0, step_count=0, divider count=0, div=DEFAULT_DIV and the step_btn sample=0, all on the next edge.
REQ-030 RST mid-RUN or mid-STEP SHALL deassert cpu_en on the next edge, with no residual step pending.

Structure
REQ-031 The shared package step_ctrl_pkg SHALL hold the state and mode enums and the DEFAULT_DIV constant.
REQ-032 The divider SHALL be a sub-module, tick_div, with ports CLK, RST, load, div_value and tick.
REQ-033 The FSM, edge detection, cpu_en register and counter SHALL reside in step_controller.

Verification
REQ-034 Bench SHALL cover: DEFAULT_DIV=4, mode STEP, step_btn held 20 cycles → exactly one cpu_en pulse 2 cycles after the registered rise, and step_count=1.
REQ-035 Bench SHALL cover: div_load with 5, mode AUTO for 30 cycles → tick at cycles 5,10,…,30, and cpu_en one cycle after each tick, giving step_count=6.
REQ-036 Bench SHALL cover: mode FREE, then halt_req high for one cycle mid-run → cpu_en 0 from the next cycle, state=11 until resume; resume then gives state=00 and step_count=0.
REQ-037 Bench SHALL cover: step event and halt_req on the same edge → HALTED, with no cpu_en pulse.
REQ-038 Bench SHALL cover: CNT_W=4, mode FREE for 20 cycles → step_count saturates at 15.
REQ-039 Bench SHALL cover: RST asserted during AUTO run → next cycle cpu_en=0, tick=0, state=00, step_count=0, and the next tick DEFAULT_DIV cycles after release.
